// File: rtl/tm1638_pkg.sv
// Shared constants and FSM encoding for the TM1638 BCD feeder.
// Digit codes match what the display driver decodes as blank and error.
package tm1638_pkg;

    localparam logic [3:0]  DIG_BLANK = 4'hF;
    localparam logic [3:0]  DIG_ERR   = 4'hE;
    localparam int unsigned NDIG_MAX  = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StFin   = 2'd2
    } state_e;

    // Constant-evaluable power of ten, used for the overflow threshold.
    function automatic longint unsigned pow10(int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/tm1638_bcd_feeder_if.sv
// Value-in / digits-out bundle between an upstream producer and the BCD feeder.
// The master drives the request side; the slave (feeder) drives status and digits.
interface tm1638_bcd_feeder_if #(
    parameter int unsigned BIN_W = 27
);
    logic             in_valid;
    logic             in_ready;
    logic [BIN_W-1:0] value;
    logic [7:0]       led_in;
    logic             busy;
    logic             out_valid;
    logic             ovf;
    logic [3:0]       seg0;
    logic [3:0]       seg1;
    logic [3:0]       seg2;
    logic [3:0]       seg3;
    logic [3:0]       seg4;
    logic [3:0]       seg5;
    logic [3:0]       seg6;
    logic [3:0]       seg7;
    logic [7:0]       led;

    modport master (
        output in_valid, value, led_in,
        input  in_ready, busy, out_valid, ovf,
        input  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7, led
    );

    modport slave (
        input  in_valid, value, led_in,
        output in_ready, busy, out_valid, ovf,
        output seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7, led
    );

endinterface

// File: rtl/tm1638_bcd_feeder_bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every nibble >= 5, then shift left
// with the next binary bit entering the LSB.
module bcd_dabble_step #(
    parameter int unsigned NDIG = 8
) (
    input  logic [4*NDIG-1:0] acc_i,
    input  logic              bit_i,
    output logic [4*NDIG-1:0] acc_o
);

    logic [4*NDIG-1:0] adj;

    always_comb begin
        adj = acc_i;
        for (int i = 0; i < int'(NDIG); i++) begin
            // A corrected nibble is at most 9+3=12, so no carry leaves the nibble.
            if (acc_i[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_i[4*i +: 4] + 4'd3;
            end
        end
        acc_o = {adj[4*NDIG-2:0], bit_i};
    end

endmodule

// File: rtl/tm1638_bcd_feeder.sv
// Binary-to-BCD feeder for the TM1638 driver: sequential double-dabble, one bit per clock,
// with optional leading-zero blanking; outputs hold until a whole result is committed.
module tm1638_bcd_feeder
    import tm1638_pkg::*;
#(
    parameter int unsigned BIN_W    = 27,
    parameter int unsigned NDIG     = 8,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic                   clkinput,
    input  logic                   rst,
    tm1638_bcd_feeder_if.slave     bus
);

    localparam int unsigned     ACC_W   = 4 * NDIG;
    localparam int unsigned     CNT_W   = $clog2(BIN_W + 1);
    localparam longint unsigned MAX_VAL = pow10(NDIG) - 1;
    localparam logic [ACC_W-1:0] SEG_RST = {{(NDIG - 1){DIG_BLANK}}, 4'h0};

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         led_pend_q, led_pend_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [ACC_W-1:0]   seg_q, seg_d;
    logic [7:0]         led_q, led_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;

    logic [ACC_W-1:0]   acc_step;
    logic [ACC_W-1:0]   seg_fmt;
    logic               ovf_next;
    logic               lead;

    bcd_dabble_step #(
        .NDIG (NDIG)
    ) u_step (
        .acc_i (acc_q),
        .bit_i (bin_q[BIN_W-1]),
        .acc_o (acc_step)
    );

    assign ovf_next = 64'(bus.value) > MAX_VAL;

    // Leading-zero blanking scans from the top digit down; seg0 always shows.
    always_comb begin
        seg_fmt = acc_q;
        lead    = 1'b1;
        for (int i = int'(NDIG) - 1; i >= 1; i--) begin
            if ((BLANK_LZ != 0) && lead && (acc_q[4*i +: 4] == 4'd0)) begin
                seg_fmt[4*i +: 4] = DIG_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
        if (ovf_pend_q) begin
            seg_fmt = {NDIG{DIG_ERR}};
        end
    end

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        led_pend_d  = led_pend_q;
        ovf_pend_d  = ovf_pend_q;
        seg_d       = seg_q;
        led_d       = led_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    bin_d      = bus.value;
                    led_pend_d = bus.led_in;
                    ovf_pend_d = ovf_next;
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = StShift;
                end
            end
            StShift: begin
                acc_d = acc_step;
                bin_d = bin_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                seg_d       = seg_fmt;
                led_d       = led_pend_q;
                ovf_d       = ovf_pend_q;
                out_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clkinput) begin
        if (rst) begin
            state_q     <= StIdle;
            bin_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            led_pend_q  <= '0;
            ovf_pend_q  <= 1'b0;
            seg_q       <= SEG_RST;
            led_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            led_pend_q  <= led_pend_d;
            ovf_pend_q  <= ovf_pend_d;
            seg_q       <= seg_d;
            led_q       <= led_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.ovf       = ovf_q;
    assign bus.led       = led_q;
    assign bus.seg0      = seg_q[3:0];
    assign bus.seg1      = seg_q[7:4];
    assign bus.seg2      = seg_q[11:8];
    assign bus.seg3      = seg_q[15:12];
    assign bus.seg4      = seg_q[19:16];
    assign bus.seg5      = seg_q[23:20];
    assign bus.seg6      = seg_q[27:24];
    assign bus.seg7      = seg_q[31:28];

endmodule

// File: tb/tb_tm1638_bcd_feeder.sv
// Scoreboard bench for tm1638_bcd_feeder: two instances (blanking on/off) share stimulus,
// expected commits are queued at accept and compared when out_valid pulses.
module tb_tm1638_bcd_feeder;

    localparam int unsigned BIN_W   = 27;
    localparam int unsigned LATENCY = BIN_W + 1;

    typedef struct {
        logic [31:0] seg_b;
        logic [31:0] seg_n;
        logic [7:0]  led;
        logic        ovf;
        int unsigned acc_cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [BIN_W-1:0] value = '0;
    logic [7:0]       led_in = '0;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;

    exp_t        sb_q[$];
    logic [31:0] hold_b   = 32'hFFFF_FFF0;
    logic [31:0] hold_n   = 32'hFFFF_FFF0;
    logic [7:0]  hold_led = 8'h00;
    logic        hold_ovf = 1'b0;
    bit          hold_en  = 1'b0;
    logic        prev_ov  = 1'b0;

    tm1638_bcd_feeder_if #(.BIN_W(BIN_W)) if0 ();
    tm1638_bcd_feeder_if #(.BIN_W(BIN_W)) if1 ();

    assign if0.in_valid = in_valid;
    assign if0.value    = value;
    assign if0.led_in   = led_in;
    assign if1.in_valid = in_valid;
    assign if1.value    = value;
    assign if1.led_in   = led_in;

    tm1638_bcd_feeder #(.BIN_W(BIN_W), .NDIG(8), .BLANK_LZ(1)) u_dut_blank (
        .clkinput (clk),
        .rst      (rst),
        .bus      (if0)
    );

    tm1638_bcd_feeder #(.BIN_W(BIN_W), .NDIG(8), .BLANK_LZ(0)) u_dut_plain (
        .clkinput (clk),
        .rst      (rst),
        .bus      (if1)
    );

    logic [31:0] segv0, segv1;
    assign segv0 = {if0.seg7, if0.seg6, if0.seg5, if0.seg4,
                    if0.seg3, if0.seg2, if0.seg1, if0.seg0};
    assign segv1 = {if1.seg7, if1.seg6, if1.seg5, if1.seg4,
                    if1.seg3, if1.seg2, if1.seg1, if1.seg0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Reference digits from plain integer arithmetic.
    function automatic logic [31:0] model_segs(input longint unsigned v, input bit blank);
        logic [31:0] s;
        longint unsigned d;
        bit lead;
        if (v > 64'd99999999) return 32'hEEEE_EEEE;
        for (int i = 0; i < 8; i++) begin
            d = v % 10;
            s[4*i +: 4] = d[3:0];
            v = v / 10;
        end
        lead = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            if (blank && lead && (s[4*i +: 4] == 4'd0)) s[4*i +: 4] = 4'hF;
            else lead = 1'b0;
        end
        return s;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_seg"}, segv0, 32'hFFFF_FFF0);
        check_eq({tag, "_seg_plain"}, segv1, 32'hFFFF_FFF0);
        check_eq({tag, "_led"}, if0.led, 8'h00);
        check_eq({tag, "_ovf"}, if0.ovf, 1'b0);
        check_eq({tag, "_ready"}, if0.in_ready, 1'b1);
        check_eq({tag, "_busy"}, if0.busy, 1'b0);
        check_eq({tag, "_ov"}, if0.out_valid, 1'b0);
    endtask

    // Caller is at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input longint unsigned v, input logic [7:0] l);
        exp_t e;
        for (int k = 0; k < 200 && if0.in_ready !== 1'b1; k++) @(negedge clk);
        check_eq("send_ready", if0.in_ready, 1'b1);
        value    = v[BIN_W-1:0];
        led_in   = l;
        in_valid = 1'b1;
        e.seg_b   = model_segs(v, 1'b1);
        e.seg_n   = model_segs(v, 1'b0);
        e.led     = l;
        e.ovf     = (v > 64'd99999999);
        e.acc_cyc = cyc + 1;
        sb_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(negedge clk);
        check_eq("drain", sb_q.size(), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (if0.out_valid === 1'b1) begin
                check_eq("ov_single", prev_ov, 1'b0);
                check_eq("ov_pair", if1.out_valid, 1'b1);
                if (sb_q.size() == 0) begin
                    check_eq("ov_unexpected", if0.out_valid, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("latency", cyc - e.acc_cyc, LATENCY);
                    check_eq("seg_blank", segv0, e.seg_b);
                    check_eq("seg_plain", segv1, e.seg_n);
                    check_eq("led", if0.led, e.led);
                    check_eq("ovf", if0.ovf, e.ovf);
                    check_eq("ovf_plain", if1.ovf, e.ovf);
                    check_eq("ready_in_ov", if0.in_ready, 1'b1);
                    hold_b   = e.seg_b;
                    hold_n   = e.seg_n;
                    hold_led = e.led;
                    hold_ovf = e.ovf;
                end
            end else if (hold_en) begin
                check_eq("hold_seg", segv0, hold_b);
                check_eq("hold_seg_plain", segv1, hold_n);
                check_eq("hold_led", if0.led, hold_led);
                check_eq("hold_ovf", if0.ovf, hold_ovf);
                check_eq("ov_pair_idle", if1.out_valid, 1'b0);
            end
            prev_ov = (if0.out_valid === 1'b1);
        end
    end

    initial begin : driver
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");
        hold_en = 1'b1;

        send(12345678, 8'hA5);
        check_eq("busy_shift", if0.busy, 1'b1);
        check_eq("ready_shift", if0.in_ready, 1'b0);
        drain();
        send(305, 8'h01);
        drain();
        send(0, 8'h02);
        drain();
        send(99999999, 8'h04);
        drain();
        send(100000000, 8'h08);
        drain();
        send(7, 8'h10);
        drain();

        // Requests while busy must be dropped without disturbing the running conversion.
        send(4321, 8'h3C);
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            value    = 27'd9999;
            led_in   = 8'hFF;
            check_eq("ignore_ready", if0.in_ready, 1'b0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 50 && if0.out_valid !== 1'b1; k++) @(negedge clk);
        check_eq("b2b_ov", if0.out_valid, 1'b1);
        send(55, 8'h55);
        drain();

        // Reset in the middle of SHIFT aborts with no commit.
        send(87654321, 8'h81);
        repeat (9) @(negedge clk);
        hold_en = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        hold_b   = 32'hFFFF_FFF0;
        hold_n   = 32'hFFFF_FFF0;
        hold_led = 8'h00;
        hold_ovf = 1'b0;
        check_reset_outputs("midreset");
        hold_en = 1'b1;
        repeat (40) @(negedge clk);
        send(2024, 8'h42);
        drain();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
